// File: rtl/pixel_combinator.sv
// pixel_combinator
//   Walks a frame in raster order, broadcasting the next expected coordinate
//   to every engine reorder queue. Pops the lowest-index queue whose head
//   matches and forwards its colour as a valid/ready stream with frame
//   markers. Also flags stalled (timeout) and ambiguous (multi-match) queues.
//
// Ports
//   clk, reset (async, active low), start (1-cycle frame kick, IDLE only)
//   match_i/colour_i     : per-queue head-match bits and head colours
//   xpixel_check/ypixel_check : expected coordinate broadcast to the queues
//   pop_o                : one-hot pop strobe, combinational
//   pix_valid/pix_ready/pix_colour/pix_sof/pix_eol/pix_eof : output stream
//   busy, done, stall_err, multi_err : status
module pixel_combinator #(
  parameter int NUM_ENGINES = 4,
  parameter int DATA_WIDTH  = 10,
  parameter int RBG_SIZE    = 24,
  parameter int X_PIXELS    = 640,
  parameter int Y_PIXELS    = 480,
  parameter int TIMEOUT     = 1023
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [NUM_ENGINES-1:0]          match_i,
  input  logic [NUM_ENGINES*RBG_SIZE-1:0] colour_i,
  output logic [DATA_WIDTH-1:0]           xpixel_check,
  output logic [DATA_WIDTH-1:0]           ypixel_check,
  output logic [NUM_ENGINES-1:0]          pop_o,
  output logic                            pix_valid,
  input  logic                            pix_ready,
  output logic [RBG_SIZE-1:0]             pix_colour,
  output logic                            pix_sof,
  output logic                            pix_eol,
  output logic                            pix_eof,
  output logic                            busy,
  output logic                            done,
  output logic                            stall_err,
  output logic                            multi_err
);

  localparam int SW = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
  localparam int TW = $clog2(TIMEOUT + 2);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                                 state_q, state_d;
  logic [DATA_WIDTH-1:0]                  x_q, y_q;
  logic [RBG_SIZE-1:0]                    col_q;
  logic                                   vld_q, sof_q, eol_q, eof_q;
  logic                                   done_q, stall_q, multi_q;
  logic [TW-1:0]                          cnt_q;

  logic [NUM_ENGINES-1:0][RBG_SIZE-1:0]   col_arr;
  logic [SW-1:0]                          sel;
  logic                                   any_m, many_m, can_pop, accept;
  logic                                   last_x, last_y;

  assign col_arr = colour_i;

  // Lowest-index match wins: scan downward so the last write is the lowest.
  always_comb begin
    sel = '0;
    for (int k = NUM_ENGINES - 1; k >= 0; k--)
      if (match_i[k]) sel = SW'(k);
  end

  assign any_m   = |match_i;
  assign many_m  = $countones(match_i) > 1;
  assign accept  = vld_q && pix_ready;
  // Output register is free when empty or being drained this cycle.
  assign can_pop = (state_q == RUN) && any_m && (!vld_q || pix_ready);
  assign pop_o   = can_pop ? (NUM_ENGINES'(1) << sel) : '0;
  assign last_x  = (x_q == DATA_WIDTH'(X_PIXELS - 1));
  assign last_y  = (y_q == DATA_WIDTH'(Y_PIXELS - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (can_pop && last_x && last_y) state_d = DRAIN;
      DRAIN:   if (accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q     <= '0;
      y_q     <= '0;
      col_q   <= '0;
      vld_q   <= 1'b0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
      done_q  <= 1'b0;
      stall_q <= 1'b0;
      multi_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      done_q <= (state_q == DRAIN) && accept;

      if (state_q == IDLE && start) begin
        x_q     <= '0;
        y_q     <= '0;
        stall_q <= 1'b0;
        multi_q <= 1'b0;
        cnt_q   <= '0;
      end

      if (can_pop) begin
        col_q <= col_arr[sel];
        vld_q <= 1'b1;
        sof_q <= (x_q == '0) && (y_q == '0);
        eol_q <= last_x;
        eof_q <= last_x && last_y;
        cnt_q <= '0;
        if (many_m) multi_q <= 1'b1;
        // Coordinates stop on the final pixel rather than wrapping.
        if (!last_x) begin
          x_q <= x_q + 1'b1;
        end else if (!last_y) begin
          x_q <= '0;
          y_q <= y_q + 1'b1;
        end
      end else if (accept) begin
        vld_q <= 1'b0;
      end

      // Stall watchdog keeps counting while nothing matches; it saturates
      // and the block keeps seeking the same coordinate.
      if (state_q == RUN && !any_m) begin
        if (cnt_q != TW'(TIMEOUT)) cnt_q <= cnt_q + 1'b1;
        if (int'(cnt_q) + 1 >= TIMEOUT) stall_q <= 1'b1;
      end
    end
  end

  assign xpixel_check = x_q;
  assign ypixel_check = y_q;
  assign pix_valid    = vld_q;
  assign pix_colour   = col_q;
  assign pix_sof      = sof_q;
  assign pix_eol      = eol_q;
  assign pix_eof      = eof_q;
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign stall_err    = stall_q;
  assign multi_err    = multi_q;

endmodule

// File: tb/tb_pixel_combinator.sv
module tb_pixel_combinator;
  localparam int NE = 4;
  localparam int DW = 10;
  localparam int CW = 24;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [NE-1:0] match_i;
  logic [NE*CW-1:0] colour_i;
  logic [DW-1:0] xchk, ychk;
  logic [NE-1:0] pop_o;
  logic          pix_valid, pix_ready;
  logic [CW-1:0] pix_colour;
  logic          sof, eol, eof, busy, done, stall_err, multi_err;

  int total = 0;
  int bad   = 0;
  int acc_cnt  = 0;
  int done_cnt = 0;
  int a0, d0;

  pixel_combinator #(
    .NUM_ENGINES(NE), .DATA_WIDTH(DW), .RBG_SIZE(CW),
    .X_PIXELS(4), .Y_PIXELS(2), .TIMEOUT(8)
  ) dut (
    .clk(clk), .reset(rst_n), .start(start),
    .match_i(match_i), .colour_i(colour_i),
    .xpixel_check(xchk), .ypixel_check(ychk),
    .pop_o(pop_o), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_colour(pix_colour), .pix_sof(sof), .pix_eol(eol), .pix_eof(eof),
    .busy(busy), .done(done), .stall_err(stall_err), .multi_err(multi_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && pix_valid && pix_ready) acc_cnt++;
    if (rst_n && done) done_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("go_busy", busy, 1);
    chk("go_x", xchk, 0);
    chk("go_y", ychk, 0);
    chk("go_valid", pix_valid, 0);
  endtask

  // Present pixel i with match pattern m; engine sel must win.
  task automatic px(input int i, input int sel, input logic [NE-1:0] m);
    logic [NE-1:0] ep;
    logic [CW-1:0] ec;
    for (int k = 0; k < NE; k++) colour_i[k*CW +: CW] = {8'(k + 1), 16'(i)};
    match_i = m;
    ep = NE'(1) << sel;
    ec = {8'(sel + 1), 16'(i)};
    #1;
    chk("pop", pop_o, ep);
    chk("xchk", xchk, i % 4);
    chk("ychk", ychk, i / 4);
    tick();
    chk("valid", pix_valid, 1);
    chk("colour", pix_colour, ec);
    chk("sof", sof, i == 0);
    chk("eol", eol, (i % 4) == 3);
    chk("eof", eof, i == 7);
  endtask

  task automatic drain();
    match_i = '0;
    #1;
    chk("drain_pop", pop_o, 0);
    chk("drain_done0", done, 0);
    tick();
    chk("drain_done1", done, 1);
    chk("drain_busy", busy, 0);
    chk("drain_valid", pix_valid, 0);
    tick();
    chk("drain_done2", done, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; match_i = '0; colour_i = '0; pix_ready = 1'b1;
    repeat (2) tick();
    chk("rst_pop", pop_o, 0);
    chk("rst_valid", pix_valid, 0);
    chk("rst_colour", pix_colour, 0);
    chk("rst_flags", {sof, eol, eof}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", {stall_err, multi_err}, 0);
    chk("rst_xy", {xchk, ychk}, 0);
    rst_n = 1'b1;
    tick();

    // single engine, full-rate frame
    go();
    a0 = acc_cnt;
    for (int i = 0; i < 8; i++) px(i, 0, 4'b0001);
    drain();
    chk("f1_acc", acc_cnt - a0, 8);

    // round-robin engines
    go();
    for (int i = 0; i < 8; i++) px(i, i % 4, 4'(1 << (i % 4)));
    drain();

    // backpressure mid-frame
    go();
    a0 = acc_cnt;
    for (int i = 0; i < 3; i++) px(i, 0, 4'b0001);
    pix_ready = 1'b0;
    match_i = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_pop", pop_o, 0);
      tick();
      chk("bp_valid", pix_valid, 1);
      chk("bp_colour", pix_colour, {8'h01, 16'd2});
      chk("bp_x", xchk, 3);
    end
    pix_ready = 1'b1;
    for (int i = 3; i < 8; i++) px(i, 0, 4'b0001);
    drain();
    chk("bp_acc", acc_cnt - a0, 8);

    // stall watchdog and multi-match
    go();
    match_i = '0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("stall_cnt", stall_err, k >= 8);
    end
    px(0, 0, 4'b0001);
    chk("stall_sticky", stall_err, 1);
    chk("multi_pre", multi_err, 0);
    px(1, 1, 4'b0110);
    chk("multi_set", multi_err, 1);
    for (int i = 2; i < 8; i++) px(i, 0, 4'b0001);
    drain();
    chk("err_hold", {stall_err, multi_err}, 2'b11);
    go();
    chk("err_clr", {stall_err, multi_err}, 2'b00);

    // reset mid-frame, then restart
    for (int i = 0; i < 3; i++) px(i, 0, 4'b0001);
    d0 = done_cnt;
    match_i = 4'b0001;
    #2 rst_n = 1'b0;
    #1;
    chk("mr_pop", pop_o, 0);
    chk("mr_valid", pix_valid, 0);
    chk("mr_colour", pix_colour, 0);
    chk("mr_busy", busy, 0);
    chk("mr_xy", {xchk, ychk}, 0);
    tick();
    rst_n = 1'b1;
    match_i = '0;
    repeat (2) tick();
    chk("mr_nodone", done_cnt - d0, 0);
    go();
    for (int i = 0; i < 8; i++) px(i, 0, 4'b0001);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pixel_combinator.md
# pixel_combinator

Raster-order reassembly controller for the pixel-engine array. Each engine writes finished pixels out of order into its own reorder queue. This block walks the frame in raster order and broadcasts the next expected coordinate to every queue. It pops the single queue whose head matches and forwards that colour downstream as a valid/ready pixel stream with frame markers. It sits between the per-engine queues and the display/stream writer, and also watches for stalled or inconsistent queues.

## Interface
- NUM_ENGINES, 4, number of engine queues served
- DATA_WIDTH, 10, coordinate width
- RBG_SIZE, 24, colour width
- X_PIXELS, 640, frame width (≤ 2^DATA_WIDTH)
- Y_PIXELS, 480, frame height (≤ 2^DATA_WIDTH)
- TIMEOUT, 1023, maximum number of consecutive no-match cycles in RUN before the stall error is set
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; asserting it (0) clears all state immediately
- start  in  1  one-cycle pulse; begins a frame when in IDLE, ignored otherwise
- match_i  in  NUM_ENGINES  queue k's head equals (xpixel_check, ypixel_check) and queue k is non-empty
- colour_i  in  NUM_ENGINES*RBG_SIZE  head colours; queue k occupies bits [k*RBG_SIZE +: RBG_SIZE]
- xpixel_check  out  DATA_WIDTH  expected x coordinate, registered
- ypixel_check  out  DATA_WIDTH  expected y coordinate, registered
- pop_o  out  NUM_ENGINES  one-hot pop strobe; queue advances its read pointer on the same rising edge
- pix_valid  out  1  output pixel valid
- pix_ready  in  1  downstream accepts the pixel when pix_valid && pix_ready
- pix_colour  out  RBG_SIZE  output colour
- pix_sof / pix_eol / pix_eof  out  1 each  first pixel of frame / last pixel of line / last pixel of frame; qualified by pix_valid
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse when the frame is fully accepted
- stall_err  out  1  sticky; cleared only by reset or start
- multi_err  out  1  sticky; more than one match bit seen in a pop cycle

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE → RUN on start: coordinates set to (0,0); stall_err, multi_err and the timeout counter cleared.
  - RUN → DRAIN on the cycle the pop for (X_PIXELS-1, Y_PIXELS-1) occurs.
  - DRAIN → IDLE when the final pixel is accepted; done pulses in that same cycle.
- Pop enable: can_pop = (state==RUN) && (|match_i) && (!pix_valid || pix_ready).
- Selection: the lowest-index set bit of match_i. pop_o is the one-hot of that index, asserted combinationally only when can_pop.
- On a pop edge:
  - pix_colour ← selected colour; pix_valid ← 1.
  - Frame flags: sof = (x==0 && y==0); eol = (x==X_PIXELS-1); eof = eol && (y==Y_PIXELS-1).
  - Coordinates advance: x+1; at X_PIXELS-1, x←0 and y+1. No wrap past the last pixel.
- Pixel accepted with no pop in the same cycle: pix_valid ← 0.
- Timeout counter counts RUN cycles with no match and resets on every pop. When it reaches TIMEOUT, stall_err ← 1; the block keeps seeking (no abort).
- multi_err is set when a pop cycle has popcount(match_i) > 1. The lowest index is still serviced.
- start while busy is ignored.

## Timing
- Reset values: pop_o=0, pix_valid=0, pix_colour=0, all flags 0, busy=0, done=0, errors 0, check coordinates (0,0), state IDLE.
- start at edge N → busy=1 after N; the check coordinates are valid from then on.
- Match in cycle C → pop_o high in C; pix_valid is high after edge C. The next coordinate is presented in C+1.
- Sustained throughput is 1 pixel/clk while match_i holds and pix_ready=1.
- Backpressure: with pix_valid=1 and pix_ready=0, pop_o=0 and the output register holds. Colour and flags stay stable until accepted.
- A pop and an accept in the same cycle (back-to-back) are legal. The output register reloads with no bubble.
- Reset asserted mid-frame: all outputs return to reset values asynchronously, with no done pulse. Queue contents are not this block's responsibility.

## Test plan
- Single engine, 4×2 frame (X_PIXELS=4, Y_PIXELS=2), match_i=1 always, pix_ready=1 → 8 consecutive pixels.
  - sof on pixel 0; eol on pixels 3 and 7; eof on pixel 7.
  - done one cycle after the last accept; pop_o high for exactly 8 cycles.
- Four engines, round-robin matches (engine = x mod 4), distinct colours → output colours in raster order and pop_o one-hot cycling 0001, 0010, 0100, 1000.
- pix_ready held low for 5 cycles mid-frame → pix_colour stable, pop_o=0 throughout; resumes with no lost or duplicated pixel.
- match_i=0 for TIMEOUT+2 cycles (TIMEOUT=8) → stall_err=1 after 8 no-match cycles; a later match still pops and stall_err stays 1.
- match_i=4'b0110 in a pop cycle → pop_o=4'b0010 and multi_err=1.
- Reset asserted at pixel 3 of 8, then start again → outputs cleared immediately, no done pulse; the new frame begins at (0,0) with sof.
